// File: rtl/scarv_cop_dispatch_if.sv
// Dispatch bus: CPU instruction/response handshake, decoder hookup and FU start/done.
// slave = dispatcher view, master = CPU/decoder/FU environment view.
interface scarv_cop_dispatch_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NFU   = 7;
    localparam int unsigned CLS_W = 3;

    logic               cpu_insn_req;
    logic               cpu_insn_ack;
    logic [XLEN-1:0]    cpu_insn_enc;
    logic [XLEN-1:0]    cpu_rs1_data;

    logic [XLEN-1:0]    id_encoded;
    logic [CLS_W-1:0]   id_class;
    logic               id_exception;

    logic [NFU-1:0]     fu_start;
    logic [XLEN-1:0]    fu_rs1_data;
    logic [NFU-1:0]     fu_done;
    logic               fu_rd_wen;
    logic [XLEN-1:0]    fu_rd_wdata;

    logic               cpu_rsp_valid;
    logic               cpu_rsp_ack;
    logic               cpu_rsp_wen;
    logic [XLEN-1:0]    cpu_rsp_wdata;
    logic               cpu_rsp_exc;

    logic               busy;

    modport slave (
        input  cpu_insn_req, cpu_insn_enc, cpu_rs1_data,
        input  id_class, id_exception,
        input  fu_done, fu_rd_wen, fu_rd_wdata,
        input  cpu_rsp_ack,
        output cpu_insn_ack, id_encoded, fu_start, fu_rs1_data,
        output cpu_rsp_valid, cpu_rsp_wen, cpu_rsp_wdata, cpu_rsp_exc, busy
    );

    modport master (
        output cpu_insn_req, cpu_insn_enc, cpu_rs1_data,
        output id_class, id_exception,
        output fu_done, fu_rd_wen, fu_rd_wdata,
        output cpu_rsp_ack,
        input  cpu_insn_ack, id_encoded, fu_start, fu_rs1_data,
        input  cpu_rsp_valid, cpu_rsp_wen, cpu_rsp_wdata, cpu_rsp_exc, busy
    );
endinterface

// File: rtl/scarv_cop_dispatch.sv
// Single-instruction coprocessor dispatcher: accept, decode-check, start one FU, wait, respond.
// Optional FU timeout abort enabled by defining SCARV_COP_DISPATCH_TIMEOUT_EN.
module scarv_cop_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    scarv_cop_dispatch_if.slave   bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NFU   = 7;
    localparam int unsigned CLS_W = 3;
    localparam int unsigned CNT_W = 7;
    localparam logic [CLS_W-1:0] CLS_NONE = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // The 7-bit saturating counter can only express timeouts of 1..128 cycles.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 128) begin : g_bad_timeout
        $error("scarv_cop_dispatch: TIMEOUT_CYCLES must be in 1..128");
    end

    state_e            state_q, state_d;
    logic [XLEN-1:0]   enc_q, enc_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [CLS_W-1:0]  cls_q, cls_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              exc_q, exc_d;

    logic              insn_ack_c;
    logic [NFU-1:0]    fu_start_c;
    logic              illegal_c;
    logic              done_c;

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_c;
`endif

    // Class 7 maps to no FU: the shifted bit falls off the top.
    function automatic logic [NFU-1:0] cls_onehot(input logic [CLS_W-1:0] c);
        return NFU'(8'd1 << c);
    endfunction

    // Next-state and handshake decode.
    always_comb begin
        state_d    = state_q;
        enc_d      = enc_q;
        rs1_d      = rs1_q;
        cls_d      = cls_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        exc_d      = exc_q;
        insn_ack_c = 1'b0;
        fu_start_c = '0;
        illegal_c  = bus.id_exception || (bus.id_class == CLS_NONE);
        done_c     = |(bus.fu_done & cls_onehot(cls_q));
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_c  = (cnt_q == TO_LAST);
`endif

        case (state_q)
            S_IDLE: begin
                insn_ack_c = bus.cpu_insn_req;
                if (bus.cpu_insn_req) begin
                    enc_d   = bus.cpu_insn_enc;
                    rs1_d   = bus.cpu_rs1_data;
                    state_d = S_ISSUE;
                end
            end

            // Decoder output is valid one cycle after the encoding is latched.
            S_ISSUE: begin
                if (illegal_c) begin
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    exc_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    fu_start_c = cls_onehot(bus.id_class);
                    cls_d      = bus.id_class;
                    state_d    = S_WAIT;
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end

            // Done is only looked at from here, so a same-cycle done with start is dropped.
            S_WAIT: begin
                if (done_c) begin
                    wen_d   = bus.fu_rd_wen;
                    wdata_d = bus.fu_rd_wdata;
                    exc_d   = 1'b0;
                    state_d = S_RESP;
                end
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
                else if (timeout_c) begin
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    exc_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : CNT_W'(cnt_q + 1'b1);
                end
`endif
            end

            S_RESP: begin
                if (bus.cpu_rsp_ack) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= S_IDLE;
            enc_q   <= '0;
            rs1_q   <= '0;
            cls_q   <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            enc_q   <= enc_d;
            rs1_q   <= rs1_d;
            cls_q   <= cls_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            exc_q   <= exc_d;
        end
    end

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Ack is masked during reset so every output reads 0 while g_reset is high.
    assign bus.cpu_insn_ack  = insn_ack_c & ~g_reset;
    assign bus.id_encoded    = enc_q;
    assign bus.fu_start      = fu_start_c;
    assign bus.fu_rs1_data   = rs1_q;
    assign bus.cpu_rsp_valid = (state_q == S_RESP);
    assign bus.cpu_rsp_wen   = wen_q;
    assign bus.cpu_rsp_wdata = wdata_q;
    assign bus.cpu_rsp_exc   = exc_q;
    assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// Scoreboard bench for scarv_cop_dispatch: bench acts as CPU, decoder and FU array.
// Encoding fields used by the bench: [2:0] class, [3] illegal, [6:4] latency-1,
// [8] wen, [9] stray done on another FU, [10] done in start cycle, [11] FU never answers.
module tb_scarv_cop_dispatch;
    localparam int unsigned TIMEOUT = 64;

    logic        g_clk   = 1'b0;
    logic        g_reset = 1'b0;
    int unsigned cyc     = 0;
    int          checks  = 0;
    int          errors  = 0;

    scarv_cop_dispatch_if bus();

    scarv_cop_dispatch #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus)
    );

    always #5 g_clk = ~g_clk;
    always @(posedge g_clk) cyc <= cyc + 1;

    assign bus.id_class     = bus.id_encoded[2:0];
    assign bus.id_exception = bus.id_encoded[3];

    typedef struct {
        logic        exc;
        logic        wen;
        logic [31:0] wdata;
        int unsigned cyc;
    } rsp_t;

    rsp_t       rsp_q[$];
    logic [6:0] start_q[$];

    function automatic logic f_illegal(input logic [31:0] e);
        return e[3] || (e[2:0] == 3'd7);
    endfunction
    function automatic int unsigned f_lat(input logic [31:0] e);
        return 32'(e[6:4]) + 1;
    endfunction
    function automatic logic [6:0] f_onehot(input logic [2:0] c);
        logic [6:0] v;
        v = '0;
        for (int i = 0; i < 7; i++) if (c == 3'(i)) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_insn_ack"},  32'(bus.cpu_insn_ack),  32'd0);
        chk({tag, "_id_enc"},    bus.id_encoded,         32'd0);
        chk({tag, "_fu_start"},  32'(bus.fu_start),      32'd0);
        chk({tag, "_fu_rs1"},    bus.fu_rs1_data,        32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.cpu_rsp_valid), 32'd0);
        chk({tag, "_rsp_wen"},   32'(bus.cpu_rsp_wen),   32'd0);
        chk({tag, "_rsp_wdata"}, bus.cpu_rsp_wdata,      32'd0);
        chk({tag, "_rsp_exc"},   32'(bus.cpu_rsp_exc),   32'd0);
        chk({tag, "_busy"},      32'(bus.busy),          32'd0);
    endtask

    // ---------------- FU array model ----------------
    logic        fu_pend = 1'b0;
    logic        fu_spur = 1'b0;
    int unsigned fu_cnt  = 0;
    int unsigned fu_lat  = 0;
    logic [2:0]  fu_cls  = '0;
    logic [31:0] fu_enc  = '0;
    logic [31:0] fu_rs1  = '0;

    always @(negedge g_clk) begin
        bus.fu_done     = '0;
        bus.fu_rd_wen   = 1'b0;
        bus.fu_rd_wdata = '0;
        if (g_reset) begin
            fu_pend = 1'b0;
        end else begin
            if (fu_pend) begin
                fu_cnt--;
                if (fu_cnt == 0) begin
                    bus.fu_done     = f_onehot(fu_cls);
                    bus.fu_rd_wen   = fu_enc[8];
                    bus.fu_rd_wdata = fu_rs1 ^ fu_enc;
                    fu_pend         = 1'b0;
                end else if (fu_spur && fu_cnt == fu_lat - 1) begin
                    bus.fu_done     = f_onehot((fu_cls == 3'd0) ? 3'd1 : 3'd0);
                    bus.fu_rd_wen   = 1'b1;
                    bus.fu_rd_wdata = ~(fu_rs1 ^ fu_enc);
                end
            end
            if (bus.fu_start != '0) begin
                if (start_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fu_start actual=%b required=0000000", bus.fu_start);
                end else begin
                    chk("fu_start", 32'(bus.fu_start), 32'(start_q.pop_front()));
                end
                fu_enc  = bus.id_encoded;
                fu_rs1  = bus.fu_rs1_data;
                fu_cls  = fu_enc[2:0];
                fu_lat  = fu_enc[11] ? 70 : f_lat(fu_enc);
                fu_cnt  = fu_lat;
                fu_spur = fu_enc[9];
                fu_pend = 1'b1;
                // A done in the start cycle carries poisoned data; it must be ignored.
                if (fu_enc[10]) begin
                    bus.fu_done     = f_onehot(fu_cls);
                    bus.fu_rd_wen   = 1'b1;
                    bus.fu_rd_wdata = ~(fu_rs1 ^ fu_enc);
                end
            end
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    int unsigned hold_req     = 0;
    int unsigned hold_left    = 0;
    int unsigned last_ack_cyc = 0;
    logic        in_rsp       = 1'b0;
    rsp_t        cur;
    logic [1:0]  held_flags;
    logic [31:0] held_wdata;

    always @(negedge g_clk) begin
        if (g_reset) begin
            in_rsp          = 1'b0;
            hold_left       = 0;
            bus.cpu_rsp_ack = 1'b0;
        end else begin
            if (bus.busy) chk("insn_ack_while_busy", 32'(bus.cpu_insn_ack), 32'd0);
            if (bus.cpu_rsp_valid) begin
                if (!in_rsp) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp actual=valid required=no_response");
                    end else begin
                        cur = rsp_q.pop_front();
                        chk("rsp_exc", 32'(bus.cpu_rsp_exc), 32'(cur.exc));
                        chk("rsp_wen", 32'(bus.cpu_rsp_wen), 32'(cur.wen));
                        if (!cur.exc) chk("rsp_wdata", bus.cpu_rsp_wdata, cur.wdata);
                        chk("rsp_cycle", cyc, cur.cyc);
                    end
                    in_rsp     = 1'b1;
                    hold_left  = hold_req;
                    hold_req   = 0;
                    held_flags = {bus.cpu_rsp_exc, bus.cpu_rsp_wen};
                    held_wdata = bus.cpu_rsp_wdata;
                end else begin
                    chk("rsp_flags_stable", 32'({bus.cpu_rsp_exc, bus.cpu_rsp_wen}), 32'(held_flags));
                    chk("rsp_wdata_stable", bus.cpu_rsp_wdata, held_wdata);
                end
                if (hold_left > 0) begin
                    bus.cpu_rsp_ack = 1'b0;
                    hold_left--;
                end else begin
                    bus.cpu_rsp_ack = ($urandom_range(0, 2) != 0);
                end
                if (bus.cpu_rsp_ack) begin
                    in_rsp       = 1'b0;
                    last_ack_cyc = cyc;
                end
            end else begin
                if (in_rsp) begin
                    checks++; errors++;
                    $display("FAIL rsp_dropped actual=valid_low required=valid_until_ack");
                    in_rsp = 1'b0;
                end
                bus.cpu_rsp_ack = 1'b0;
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic issue(input logic [31:0] enc, input logic [31:0] rs1, output int unsigned acc);
        int unsigned budget;
        rsp_t        r;
        budget = 0;
        @(negedge g_clk);
        bus.cpu_insn_req = 1'b1;
        bus.cpu_insn_enc = enc;
        bus.cpu_rs1_data = rs1;
        #1;
        while (bus.cpu_insn_ack !== 1'b1 && budget < 400) begin
            @(negedge g_clk);
            #1;
            budget++;
        end
        acc = cyc;
        if (budget >= 400) begin
            checks++; errors++;
            $display("FAIL insn_accept_timeout actual=no_ack required=ack");
            bus.cpu_insn_req = 1'b0;
        end else begin
            if (f_illegal(enc)) begin
                r = '{exc: 1'b1, wen: 1'b0, wdata: 32'd0, cyc: acc + 2};
            end else begin
                start_q.push_back(f_onehot(enc[2:0]));
                if (enc[11]) r = '{exc: 1'b1, wen: 1'b0, wdata: 32'd0, cyc: acc + 2 + TIMEOUT};
                else         r = '{exc: 1'b0, wen: enc[8], wdata: rs1 ^ enc, cyc: acc + 2 + f_lat(enc)};
            end
            rsp_q.push_back(r);
            @(posedge g_clk);
        end
    endtask

    task automatic drain();
        int unsigned b;
        b = 0;
        @(negedge g_clk);
        bus.cpu_insn_req = 1'b0;
        while ((rsp_q.size() != 0 || bus.busy) && b < 400) begin
            @(negedge g_clk);
            b++;
        end
        if (b >= 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=busy required=idle");
        end
    endtask

    task automatic pulse_reset(input string tag);
        #1 g_reset = 1'b1;
        #1 chk_zero(tag);
        rsp_q.delete();
        start_q.delete();
        @(negedge g_clk);
        #1 g_reset = 1'b0;
    endtask

    initial begin
        forever begin
            #2000000;
            $display("FAIL watchdog actual=running required=finished");
            $fatal(1, "watchdog expired");
        end
    end

    initial begin
        int unsigned acc, acc2, b;
        logic [31:0] e;
        bus.cpu_insn_req = 1'b0;
        bus.cpu_insn_enc = '0;
        bus.cpu_rs1_data = '0;
        #1 g_reset = 1'b1;
        bus.cpu_insn_req = 1'b1;
        repeat (2) @(negedge g_clk);
        #1 chk_zero("reset");
        bus.cpu_insn_req = 1'b0;
        @(negedge g_clk);
        g_reset = 1'b0;

        // mp class, 3-cycle FU, wdata 0xDEADBEEF
        issue(32'h0000_0125, 32'hDEADBEEF ^ 32'h0000_0125, acc); drain();
        // decoder exception, class 7, minimum-latency class 0
        issue(32'h0000_0009, 32'h1234_5678, acc); drain();
        issue(32'h0000_0007, 32'h0BAD_F00D, acc); drain();
        issue(32'h0000_0100, 32'hCAFE_0001, acc); drain();
        // done in the start cycle, then stray fu_done[0] while class 2 waits
        issue(32'h0000_0513, 32'h5555_AAAA, acc); drain();
        issue(32'h0000_0332, 32'hA5A5_0F0F, acc); drain();

        // response back-pressure with a second request already waiting
        hold_req = 10;
        issue(32'h0000_0141, 32'h0101_0101, acc);
        issue(32'h0000_0106, 32'h0202_0202, acc2);
        chk("accept_after_ack", acc2, last_ack_cyc + 1);
        drain();

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
        // FU never answers in time; its late done must leave the block idle
        issue(32'h0000_0804, 32'h7777_7777, acc); drain();
        b = 0;
        while (fu_pend && b < 200) begin @(negedge g_clk); b++; end
        repeat (3) @(negedge g_clk);
        chk("stale_done_busy", 32'(bus.busy), 32'd0);
        chk("stale_done_valid", 32'(bus.cpu_rsp_valid), 32'd0);
`endif

        // reset in WAIT drops the operation
        issue(32'h0000_0171, 32'h3333_3333, acc);
        @(negedge g_clk); bus.cpu_insn_req = 1'b0;
        @(negedge g_clk);
        pulse_reset("rst_wait");
        issue(32'h0000_0124, 32'h4444_4444, acc); drain();

        // reset in RESP drops the pending response
        hold_req = 20;
        issue(32'h0000_000E, 32'h6666_6666, acc);
        @(negedge g_clk); bus.cpu_insn_req = 1'b0;
        b = 0;
        while (!bus.cpu_rsp_valid && b < 50) begin @(negedge g_clk); #1; b++; end
        @(negedge g_clk);
        pulse_reset("rst_resp");
        issue(32'h0000_0116, 32'h8888_8888, acc); drain();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            e     = $urandom;
            e[11] = 1'b0;
            e[3]  = ($urandom_range(0, 7) == 0);
            issue(e, $urandom, acc);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge g_clk);
                bus.cpu_insn_req = 1'b0;
                repeat ($urandom_range(1, 6)) @(negedge g_clk);
            end
        end
        drain();
        repeat (3) @(negedge g_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scarv_cop_dispatch.md
SCARV_COP_DISPATCH -- requirements
Module: scarv_cop_dispatch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum number of cycles one FU operation may run before it is aborted.
REQ-002 g_clk  in  1  is the single clock; all state updates on its rising edge.
REQ-003 g_reset  in  1  is the asynchronous, active-high reset.
REQ-004 cpu_insn_req  in  1  means the CPU presents an instruction.
REQ-005 cpu_insn_ack  out  1  means the instruction is accepted on this cycle.
REQ-006 cpu_insn_enc  in  32  is the encoded instruction.
REQ-007 cpu_rs1_data  in  32  is the GPR rs1 value sampled with the instruction.
REQ-008 id_encoded  out  32  drives the decoder input.
REQ-009 id_class  in  3  is the decoder class: 0 packed-arith, 1 twiddle, 2 load/store, 3 random, 4 move, 5 mp, 6 bitwise, 7 none.
REQ-010 id_exception  in  1  is the decoder illegal-instruction flag.
REQ-011 fu_start  out  7  is a one-hot start pulse, bit index equal to the class.
REQ-012 fu_rs1_data  out  32  is the latched rs1 value to the FUs.
REQ-013 fu_done  in  7  is the per-FU completion pulse.
REQ-014 fu_rd_wen / fu_rd_wdata  in  1/32  carry the GPR writeback from the completing FU.
REQ-015 cpu_rsp_valid  out  1  means a response is pending.
REQ-016 cpu_rsp_ack  in  1  means the CPU consumes the response.
REQ-017 cpu_rsp_wen / cpu_rsp_wdata / cpu_rsp_exc  out  1/32/1  carry the response payload.
REQ-018 busy  out  1  is high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-020 In IDLE, cpu_insn_ack SHALL equal cpu_insn_req combinationally; on req&ack the block latches enc and rs1 and moves to ISSUE.
REQ-021 id_encoded SHALL always drive the latched encoding.
REQ-022 In ISSUE, if id_exception=1 or id_class=7, the block SHALL go to RESP with cpu_rsp_exc=1 and cpu_rsp_wen=0 and pulse no FU.
REQ-023 Otherwise in ISSUE, fu_start[id_class] SHALL pulse for exactly one cycle, the class is latched, and the FSM goes to WAIT.
REQ-024 In WAIT, only fu_done[latched class] is honoured; done bits for other classes SHALL be ignored.
REQ-025 When done is seen, the block SHALL latch fu_rd_wen and fu_rd_wdata and go to RESP with exc=0.
REQ-026 A done pulse arriving in the same cycle as the start pulse SHALL NOT be honoured; minimum FU latency is 1 cycle.
REQ-027 In RESP, cpu_rsp_valid=1 and the payload SHALL be held stable until cpu_rsp_ack, then the FSM returns to IDLE.
REQ-028 cpu_insn_ack SHALL be 0 outside IDLE, and the block never holds more than one instruction.
REQ-029 Minimum round trip SHALL be accept at cycle N, start at N+1, done at N+2, rsp_valid at N+3.
REQ-030 The timeout counter is 7 bits wide, saturating, and is cleared on entry to WAIT.

Reset
REQ-031 On g_reset, the state SHALL become IDLE asynchronously.
REQ-032 On g_reset, all outputs SHALL be 0, all latches 0 and the counter 0.
REQ-033 A reset asserted mid-WAIT or mid-RESP SHALL drop the pending operation with no response emitted.

Configuration
REQ-034 With SCARV_COP_DISPATCH_TIMEOUT_EN defined, a WAIT lasting TIMEOUT_CYCLES cycles without a valid done SHALL go to RESP with exc=1 and wen=0, and a later stale done SHALL be ignored.
REQ-035 With SCARV_COP_DISPATCH_TIMEOUT_EN undefined, the counter SHALL be absent and WAIT SHALL persist indefinitely until done.

Verification
REQ-036 Valid mp instruction with class=5, done 3 cycles after start, wen=1, wdata=0xDEADBEEF -> fu_start=7'b0100000 for one cycle, and the response is wen=1, wdata=0xDEADBEEF, exc=0.
REQ-037 Decoder reports id_exception=1 -> fu_start stays 0 and rsp_valid is asserted at the next cycle with exc=1.
REQ-038 rsp_ack held low for 10 cycles while cpu_insn_req=1 -> payload stays stable, insn_ack=0 throughout, and the new instruction is accepted on the cycle after ack.
REQ-039 Class 2 in flight with a fu_done[0] pulse -> the pulse is ignored, and only fu_done[2] completes the operation.
REQ-040 With TIMEOUT_EN defined and no done for 64 cycles -> exc=1 response, and a done on cycle 70 has no effect.
REQ-041 g_reset pulsed during WAIT -> all outputs are 0 immediately, and the next request is accepted normally.
